uart_baudgen_frac: RTL and testbench
====================================

UART_BAUDGEN_FRAC -- requirements
Module: uart_baudgen_frac

Interface
REQ-001 SHALL have parameter DIV_W, default 16, integer divisor width.
REQ-002 SHALL have parameter FRAC_W, default 4, fractional divisor width.
REQ-003 SHALL have parameter OVS, default 16, oversample factor; power of two, 4..32.
REQ-004 SHALL have port clk_i, input, 1, sole clock.
REQ-005 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port en_i, input, 1, generator enable.
REQ-007 SHALL have port divisor_i, input, DIV_W, integer divisor D in clk cycles per oversample tick.
REQ-008 SHALL have port frac_i, input, FRAC_W, fractional divisor F, in units of 1/2^FRAC_W cycle.
REQ-009 SHALL have port cfg_update_i, input, 1, single-cycle pulse on divisor write.
REQ-010 SHALL have port align_i, input, 1, phase realign (RX start-edge detect).
REQ-011 SHALL have port oversample_tick_o, output, 1, oversample-rate strobe.
REQ-012 SHALL have port half_tick_o, output, 1, mid-bit strobe.
REQ-013 SHALL have port baud_tick_o, output, 1, bit-boundary strobe.
REQ-014 SHALL have port phase_o, output, $clog2(OVS), current oversample phase.

Function
REQ-015 SHALL clock a prescaler through each enabled cycle, counting 0..P-1 and wrapping, where P = D, or D+1 when the previous wrap produced a fractional carry.
REQ-016 SHALL, on every prescaler wrap, update a FRAC_W accumulator to acc+F mod 2^FRAC_W; carry-out SHALL set P = D+1 for the next period only.
REQ-017 SHALL assert oversample_tick_o high for exactly one cycle per prescaler wrap, registered (cycle after terminal count); with F=0 ticks SHALL be spaced exactly D cycles.
REQ-018 SHALL increment phase counter (0..OVS-1, wrapping) on each oversample tick; phase_o reflects it.
REQ-019 SHALL assert baud_tick_o coincident with the oversample tick on which phase wraps OVS-1 -> 0.
REQ-020 SHALL assert half_tick_o coincident with the oversample tick on which phase goes OVS/2-1 -> OVS/2.
REQ-021 SHALL, when D == 0, hold all counters and keep all tick outputs low; D == 1, F == 0 SHALL yield a tick every cycle.
REQ-022 SHALL, when en_i low, hold prescaler, accumulator and phase, and drive all ticks low; resume from held state on re-enable.
REQ-023 SHALL, on cfg_update_i or align_i, clear prescaler, accumulator and phase in the next cycle and suppress any tick that cycle; this has priority over en_i and over a coincident terminal count.
REQ-024 SHALL sample divisor_i/frac_i every cycle; changes without cfg_update_i take effect at the next prescaler wrap comparison, never producing a period shorter than min(old, new) D.
REQ-025 SHALL guarantee after align_i: first half_tick_o after OVS/2 ticks, first baud_tick_o after OVS ticks.

Reset
REQ-026 SHALL, in reset, clear prescaler, accumulator, phase and all output flops; all outputs 0.
REQ-027 SHALL start counting on the first enabled edge after rst_ni deasserts; no tick in that cycle.

Structure
REQ-028 SHALL place a baud-config struct (divisor, frac) and OVS default constant in uart_pkg.
REQ-029 SHALL implement prescaler+accumulator as sub-module uart_frac_prescaler; phase/strobe logic in the top.
REQ-030 SHALL use the common_cells counter and FF macros for state flops.

Verification
REQ-031 D=4, F=0, OVS=16, en high -> oversample ticks every 4 cycles, baud_tick every 64, half_tick 32 cycles after each baud_tick.
REQ-032 D=4, F=8, FRAC_W=4 -> tick periods 4,4,5,4,5,...; 16 ticks span exactly 72 cycles.
REQ-033 align_i pulse mid-bit with D=2 -> phase_o 0 next cycle, half_tick 16 cycles later, baud_tick 32 cycles after align.
REQ-034 en_i low for 10 cycles mid-period -> no ticks, phase_o frozen; period completes with exactly the remaining cycles.
REQ-035 D=0 -> no ticks for 1000 cycles; then D=1, cfg_update_i -> tick every cycle, baud_tick every 16.
REQ-036 rst_ni asserted mid-period -> all outputs 0 asynchronously; after release, first tick D cycles after first enabled edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the fractional UART baud generator.
// Holds the baud configuration record and the prescaler step encoding.
package uart_pkg;

  localparam int unsigned OVS_DEFAULT    = 16;
  localparam int unsigned DIV_W_DEFAULT  = 16;
  localparam int unsigned FRAC_W_DEFAULT = 4;

  // One baud setting as written by software: cycles per oversample tick D + F/2^FRAC_W.
  typedef struct packed {
    logic [DIV_W_DEFAULT-1:0]  divisor;
    logic [FRAC_W_DEFAULT-1:0] frac;
  } baud_cfg_t;

  // What the prescaler does on a given clock edge.
  typedef enum logic [1:0] {
    PS_HOLD,
    PS_COUNT,
    PS_WRAP,
    PS_CLEAR
  } ps_op_e;

endpackage

// File: rtl/uart_baudgen_frac_if.sv
// Bundles the baud generator's configuration inputs and strobe outputs so a
// driver (master) and the generator side (slave) can share one connection.
interface uart_baudgen_frac_if #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OVS    = 16
);
  localparam int unsigned PH_W = $clog2(OVS);

  logic              en;
  logic [DIV_W-1:0]  divisor;
  logic [FRAC_W-1:0] frac;
  logic              cfg_update;
  logic              align;
  logic              oversample_tick;
  logic              half_tick;
  logic              baud_tick;
  logic [PH_W-1:0]   phase;

  modport master (
    output en, divisor, frac, cfg_update, align,
    input  oversample_tick, half_tick, baud_tick, phase
  );

  modport slave (
    input  en, divisor, frac, cfg_update, align,
    output oversample_tick, half_tick, baud_tick, phase
  );

endinterface

// File: rtl/uart_frac_prescaler.sv
// Fractional-N prescaler: counts D or D+1 cycles per period, choosing D+1 for
// one period whenever the F accumulator carried on the previous wrap.
module uart_frac_prescaler
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [DIV_W-1:0]  divisor_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              wrap_o,
  output logic              tick_o
);

  logic [DIV_W-1:0]  cnt_q,   cnt_d;
  logic [FRAC_W-1:0] acc_q,   acc_d;
  logic              carry_q, carry_d;
  logic              tick_q,  tick_d;
  logic [DIV_W:0]    term_cnt;
  ps_op_e            op;

  // ">=" rather than "==" lets a divisor shrunk mid-period end the period
  // immediately instead of running the counter all the way round.
  always_comb begin
    term_cnt = {1'b0, divisor_i} + (DIV_W+1)'(carry_q) - (DIV_W+1)'(1);
    if (clear_i) begin
      op = PS_CLEAR;
    end else if (!en_i || (divisor_i == '0)) begin
      op = PS_HOLD;
    end else if ({1'b0, cnt_q} >= term_cnt) begin
      op = PS_WRAP;
    end else begin
      op = PS_COUNT;
    end
  end

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    tick_d  = 1'b0;
    unique case (op)
      PS_CLEAR: begin
        cnt_d   = '0;
        acc_d   = '0;
        carry_d = 1'b0;
      end
      PS_COUNT: cnt_d = cnt_q + DIV_W'(1);
      PS_WRAP: begin
        cnt_d              = '0;
        {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, frac_i};
        tick_d             = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      tick_q  <= tick_d;
    end
  end

  assign wrap_o = (op == PS_WRAP);
  assign tick_o = tick_q;

endmodule

// File: rtl/uart_baudgen_frac.sv
// Fractional UART baud generator: oversample strobe from the prescaler, plus
// oversample phase, mid-bit and bit-boundary strobes aligned to that strobe.
module uart_baudgen_frac
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned OVS    = OVS_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic [DIV_W-1:0]        divisor_i,
  input  logic [FRAC_W-1:0]       frac_i,
  input  logic                    cfg_update_i,
  input  logic                    align_i,
  output logic                    oversample_tick_o,
  output logic                    half_tick_o,
  output logic                    baud_tick_o,
  output logic [$clog2(OVS)-1:0]  phase_o
);

  localparam int unsigned    PH_W     = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);

  logic            clear;
  logic            wrap;
  logic            os_tick;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            half_q,  half_d;
  logic            baud_q,  baud_d;

  // A divisor write and an RX start edge both restart the bit timing from zero.
  assign clear = cfg_update_i | align_i;

  uart_frac_prescaler #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_prescaler (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .clear_i   (clear),
    .divisor_i (divisor_i),
    .frac_i    (frac_i),
    .wrap_o    (wrap),
    .tick_o    (os_tick)
  );

  // Strobes are registered from the same wrap as the oversample tick, so all three line up.
  always_comb begin
    phase_d = phase_q;
    half_d  = 1'b0;
    baud_d  = 1'b0;
    if (clear) begin
      phase_d = '0;
    end else if (wrap) begin
      phase_d = phase_q + PH_W'(1);
      baud_d  = (phase_q == PH_LAST);
      half_d  = (phase_q == PH_MID);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      half_q  <= 1'b0;
      baud_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      half_q  <= half_d;
      baud_q  <= baud_d;
    end
  end

  assign oversample_tick_o = os_tick;
  assign half_tick_o       = half_q;
  assign baud_tick_o       = baud_q;
  assign phase_o           = phase_q;

  a_baud_on_tick: assert property (@(posedge clk_i) disable iff (!rst_ni)
    baud_tick_o |-> oversample_tick_o);
  a_half_on_tick: assert property (@(posedge clk_i) disable iff (!rst_ni)
    half_tick_o |-> oversample_tick_o);

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Self-checking bench for uart_baudgen_frac: directed timing scenarios with
// literal expectations plus randomized traffic against a period-level model.
module tb_uart_baudgen_frac;
  import uart_pkg::*;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   tq[$];
  int   hq[$];
  int   bq[$];

  uart_baudgen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) bus ();

  uart_baudgen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .en_i              (bus.en),
    .divisor_i         (bus.divisor),
    .frac_i            (bus.frac),
    .cfg_update_i      (bus.cfg_update),
    .align_i           (bus.align),
    .oversample_tick_o (bus.oversample_tick),
    .half_tick_o       (bus.half_tick),
    .baud_tick_o       (bus.baud_tick),
    .phase_o           (bus.phase)
  );

  always #5 clk = ~clk;

  // Reference: el = enabled cycles spent in the current period, nt = total ticks since clear.
  typedef struct {
    int el;
    int acc;
    int ext;
    int nt;
    bit tk;
    bit hf;
    bit bd;
  } mstate_t;

  mstate_t m = '{default: 0};

  function automatic mstate_t model_next(input mstate_t s, input bit en, input bit clr,
                                         input int d, input int f);
    mstate_t n = s;
    n.tk = 0;
    n.hf = 0;
    n.bd = 0;
    if (clr) begin
      n = '{default: 0};
    end else if (en && d != 0) begin
      n.el = s.el + 1;
      if (n.el >= d + s.ext) begin
        n.el  = 0;
        n.acc = s.acc + f;
        n.ext = (n.acc >= 2 ** FRAC_W) ? 1 : 0;
        n.acc = n.acc % (2 ** FRAC_W);
        n.nt  = s.nt + 1;
        n.tk  = 1;
        n.bd  = (n.nt % OVS) == 0;
        n.hf  = (n.nt % OVS) == OVS / 2;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{default: 0};
    end else begin
      m   <= model_next(m, bus.en, bus.cfg_update | bus.align,
                        int'(bus.divisor), int'(bus.frac));
      cyc <= cyc + 1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Every-cycle compare against the model, plus a log of strobe cycles for the directed checks.
  always @(posedge clk) begin
    #1;
    check("os_tick", bus.oversample_tick, m.tk);
    check("half_tick", bus.half_tick, m.hf);
    check("baud_tick", bus.baud_tick, m.bd);
    check("phase", bus.phase, m.nt % OVS);
    if (bus.oversample_tick) tq.push_back(cyc);
    if (bus.half_tick)       hq.push_back(cyc);
    if (bus.baud_tick)       bq.push_back(cyc);
  end

  task automatic start_run(input int d, input int f, output int base);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.divisor = DIV_W'(d);
    bus.frac    = FRAC_W'(f);
    bus.en      = 1'b1;
    bus.cfg_update = 1'b0;
    bus.align   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    tq.delete();
    hq.delete();
    bq.delete();
  endtask

  initial begin
    int b;
    int a;
    int ph;
    baud_cfg_t rcfg;

    bus.en = 1'b0;
    bus.divisor = '0;
    bus.frac = '0;
    bus.cfg_update = 1'b0;
    bus.align = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_os_tick", bus.oversample_tick, 0);
    check("rst_half", bus.half_tick, 0);
    check("rst_baud", bus.baud_tick, 0);
    check("rst_phase", bus.phase, 0);

    // D=4, F=0: ticks every 4, baud every 64, half 32 after baud.
    start_run(4, 0, b);
    repeat (130) @(negedge clk);
    check("d4_tick0", qat(tq, 0), b + 4);
    check("d4_tick1", qat(tq, 1), b + 8);
    check("d4_tick31", qat(tq, 31), b + 128);
    check("d4_half0", qat(hq, 0), b + 32);
    check("d4_baud0", qat(bq, 0), b + 64);
    check("d4_half1", qat(hq, 1), b + 96);
    check("d4_baud1", qat(bq, 1), b + 128);

    // D=4, F=8: periods 4,4,5,4,5,... and 16 intervals span 72 cycles.
    start_run(4, 8, b);
    repeat (100) @(negedge clk);
    check("frac_tick0", qat(tq, 0), b + 4);
    check("frac_tick1", qat(tq, 1), b + 8);
    check("frac_tick2", qat(tq, 2), b + 13);
    check("frac_tick3", qat(tq, 3), b + 17);
    check("frac_span16", qat(tq, 16) - qat(tq, 0), 72);

    // Align mid-bit with D=2, landing on a terminal-count edge.
    start_run(2, 0, b);
    repeat (21) @(negedge clk);
    check("pre_align_phase", bus.phase, 10);
    bus.align = 1'b1;
    a = cyc + 1;
    hq.delete();
    bq.delete();
    @(posedge clk);
    #2;
    check("align_phase", bus.phase, 0);
    check("align_no_tick", bus.oversample_tick, 0);
    @(negedge clk);
    bus.align = 1'b0;
    repeat (40) @(negedge clk);
    check("align_half", qat(hq, 0), a + 16);
    check("align_baud", qat(bq, 0), a + 32);

    // Enable dropped for 10 cycles, 3 cycles into the second D=8 period.
    start_run(8, 0, b);
    repeat (11) @(negedge clk);
    bus.en = 1'b0;
    repeat (10) @(negedge clk);
    check("en_phase_frozen", bus.phase, 1);
    check("en_no_ticks", tq.size(), 1);
    bus.en = 1'b1;
    repeat (9) @(negedge clk);
    check("en_tick_count", tq.size(), 2);
    check("en_resume_tick", qat(tq, 1), b + 26);

    // D=0 holds everything; then D=1 with a config write.
    start_run(0, 0, b);
    repeat (1000) @(negedge clk);
    check("d0_no_ticks", tq.size(), 0);
    check("d0_phase", bus.phase, 0);
    bus.divisor = DIV_W'(1);
    bus.cfg_update = 1'b1;
    a = cyc + 1;
    tq.delete();
    hq.delete();
    bq.delete();
    @(negedge clk);
    bus.cfg_update = 1'b0;
    repeat (40) @(negedge clk);
    check("d1_tick0", qat(tq, 0), a + 1);
    check("d1_tick1", qat(tq, 1), a + 2);
    check("d1_half0", qat(hq, 0), a + 8);
    check("d1_baud0", qat(bq, 0), a + 16);
    check("d1_baud1", qat(bq, 1), a + 32);

    // Asynchronous reset mid-period, then restart.
    start_run(5, 0, b);
    repeat (23) @(negedge clk);
    check("pre_rst_phase", bus.phase, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_os_tick", bus.oversample_tick, 0);
    check("arst_half", bus.half_tick, 0);
    check("arst_baud", bus.baud_tick, 0);
    check("arst_phase", bus.phase, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    tq.delete();
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("post_rst_tick0", qat(tq, 0), b + 5);
    check("post_rst_tick1", qat(tq, 1), b + 10);

    // Randomized traffic, checked every cycle against the model.
    start_run(3, 5, b);
    for (int i = 0; i < 4000; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      bus.cfg_update = 1'b0;
      bus.align = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 39) == 0) begin
        rcfg.divisor = DIV_W'($urandom_range(0, 6));
        rcfg.frac    = FRAC_W'($urandom_range(0, 15));
        bus.divisor  = rcfg.divisor;
        bus.frac     = rcfg.frac;
        bus.cfg_update = ($urandom_range(0, 1) == 0);
      end
      @(negedge clk);
    end
    bus.align = 1'b0;
    bus.cfg_update = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
